// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file write-target encodings, register numbering, operand width.
// Also holds the issue-packet struct and the write-target decoder used by fetch and bypass.
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int HALF     = XLEN / 2;
  localparam int RF_DEPTH = 16;
  localparam int RF_IDX_W = $clog2(RF_DEPTH);

  localparam logic [RF_IDX_W-1:0] REG_HI  = 4'd10;
  localparam logic [RF_IDX_W-1:0] REG_AUX = 4'd11;

  localparam logic [1:0] RF_CTRL_FULL = 2'b00;
  localparam logic [1:0] RF_CTRL_HI   = 2'b01;
  localparam logic [1:0] RF_CTRL_LO   = 2'b10;
  localparam logic [1:0] RF_CTRL_AUX  = 2'b11;

  typedef struct packed {
    logic [5:0]      op;
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] t;
    logic [XLEN-1:0] d;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            wr;
    logic [1:0]      wr_sel;
  } ex_pkt_t;

  // Half-word writes always land in r10; the AUX select always lands in r11.
  function automatic logic [RF_IDX_W-1:0] rf_target(input logic [1:0] ctrl,
                                                    input logic [RF_IDX_W-1:0] addr);
    case (ctrl)
      RF_CTRL_HI, RF_CTRL_LO: return REG_HI;
      RF_CTRL_AUX:            return REG_AUX;
      default:                return addr;
    endcase
  endfunction

endpackage

// File: rtl/rf_bypass.sv
// Forwards a same-cycle register-file write onto one read operand, merging half-word writes.
// Purely combinational.
module rf_bypass
  import cpu_pkg::*;
(
  input  logic [RF_IDX_W-1:0] idx,
  input  logic [XLEN-1:0]     rf_data,
  input  logic                wb_we,
  input  logic [1:0]          wb_control,
  input  logic [RF_IDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  output logic [XLEN-1:0]     fwd
);

  logic hit;

  assign hit = wb_we && (rf_target(wb_control, wb_addr) == idx);

  always_comb begin
    fwd = rf_data;
    if (hit) begin
      case (wb_control)
        RF_CTRL_HI: fwd[XLEN-1:HALF] = wb_data[XLEN-1:HALF];
        RF_CTRL_LO: fwd[HALF-1:0]    = wb_data[HALF-1:0];
        default:    fwd              = wb_data;
      endcase
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads the RF, bypasses writeback, tracks pending writes, issues to execute.
// One cycle decode-to-execute; stalls decode on a busy source or a full, unaccepted execute slot.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [5:0]      dec_op,
  input  logic [4:0]      dec_addr_s,
  input  logic [4:0]      dec_addr_t,
  input  logic [4:0]      dec_addr_d,
  input  logic [15:0]     dec_imm,
  input  logic            dec_wr,
  input  logic [1:0]      dec_wr_sel,
  output logic [4:0]      addr_source,
  output logic [4:0]      addr_temp,
  output logic [4:0]      addr_dest,
  input  logic [XLEN-1:0] rf_s_data,
  input  logic [XLEN-1:0] rf_t_data,
  input  logic [XLEN-1:0] rf_d_data,
  input  logic            wb_we,
  input  logic [1:0]      wb_control,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [5:0]      ex_op,
  output logic [XLEN-1:0] ex_s,
  output logic [XLEN-1:0] ex_t,
  output logic [XLEN-1:0] ex_d,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_wr,
  output logic [1:0]      ex_wr_sel
);

  logic [RF_DEPTH-1:0] busy;
  logic [RF_DEPTH-1:0] clr_vec;
  logic [RF_DEPTH-1:0] set_vec;
  logic [RF_IDX_W-1:0] wb_tgt;
  logic [RF_IDX_W-1:0] dec_tgt;
  logic [XLEN-1:0]     fwd_s;
  logic [XLEN-1:0]     fwd_t;
  logic [XLEN-1:0]     fwd_d;
  logic                hazard;
  logic                issue;
  ex_pkt_t             ex_q;
  ex_pkt_t             ex_nxt;
  logic                unused_addr_msb;

  assign addr_source = dec_addr_s;
  assign addr_temp   = dec_addr_t;
  assign addr_dest   = dec_addr_d;

  // Only 16 registers exist, so the top address bit never selects anything.
  assign unused_addr_msb = wb_addr[4];

  assign wb_tgt  = rf_target(wb_control, wb_addr[RF_IDX_W-1:0]);
  assign dec_tgt = rf_target(dec_wr_sel, dec_addr_d[RF_IDX_W-1:0]);

  always_comb begin
    clr_vec = '0;
    if (wb_we) clr_vec[wb_tgt] = 1'b1;
  end

  always_comb begin
    set_vec = '0;
    if (issue && dec_wr) set_vec[dec_tgt] = 1'b1;
  end

  // A source whose pending write lands this cycle is served by the bypass, not stalled.
  assign hazard = (busy[dec_addr_s[RF_IDX_W-1:0]] & ~clr_vec[dec_addr_s[RF_IDX_W-1:0]])
                | (busy[dec_addr_t[RF_IDX_W-1:0]] & ~clr_vec[dec_addr_t[RF_IDX_W-1:0]])
                | (busy[dec_addr_d[RF_IDX_W-1:0]] & ~clr_vec[dec_addr_d[RF_IDX_W-1:0]]);

  assign dec_ready = (!ex_valid || ex_ready) && !hazard;
  assign issue     = dec_valid && dec_ready;

  rf_bypass u_byp_s (
    .idx(dec_addr_s[RF_IDX_W-1:0]), .rf_data(rf_s_data), .wb_we(wb_we),
    .wb_control(wb_control), .wb_addr(wb_addr[RF_IDX_W-1:0]), .wb_data(wb_data), .fwd(fwd_s)
  );
  rf_bypass u_byp_t (
    .idx(dec_addr_t[RF_IDX_W-1:0]), .rf_data(rf_t_data), .wb_we(wb_we),
    .wb_control(wb_control), .wb_addr(wb_addr[RF_IDX_W-1:0]), .wb_data(wb_data), .fwd(fwd_t)
  );
  rf_bypass u_byp_d (
    .idx(dec_addr_d[RF_IDX_W-1:0]), .rf_data(rf_d_data), .wb_we(wb_we),
    .wb_control(wb_control), .wb_addr(wb_addr[RF_IDX_W-1:0]), .wb_data(wb_data), .fwd(fwd_d)
  );

  always_comb begin
    ex_nxt.op     = dec_op;
    ex_nxt.s      = fwd_s;
    ex_nxt.t      = fwd_t;
    ex_nxt.d      = fwd_d;
    ex_nxt.imm    = {{(XLEN-16){dec_imm[15]}}, dec_imm};
    ex_nxt.rd     = dec_addr_d;
    ex_nxt.wr     = dec_wr;
    ex_nxt.wr_sel = dec_wr_sel;
  end

  // Set is applied after clear so a same-cycle issue keeps its target reserved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      ex_q     <= ex_nxt;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_op     = ex_q.op;
  assign ex_s      = ex_q.s;
  assign ex_t      = ex_q.t;
  assign ex_d      = ex_q.d;
  assign ex_imm    = ex_q.imm;
  assign ex_rd     = ex_q.rd;
  assign ex_wr     = ex_q.wr;
  assign ex_wr_sel = ex_q.wr_sel;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: owns a 16-entry register file, runs a reference model of issue,
// bypass and scoreboard, compares every cycle, and pins key cases with literal expectations.
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_op;
  logic [4:0]  dec_addr_s, dec_addr_t, dec_addr_d;
  logic [15:0] dec_imm;
  logic        dec_wr;
  logic [1:0]  dec_wr_sel;
  logic [4:0]  addr_source, addr_temp, addr_dest;
  logic [31:0] rf_s_data, rf_t_data, rf_d_data;
  logic        wb_we;
  logic [1:0]  wb_control;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_op;
  logic [31:0] ex_s, ex_t, ex_d, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_wr;
  logic [1:0]  ex_wr_sel;

  logic [31:0] rf [16];

  int passed = 0;
  int total  = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_addr_s(dec_addr_s), .dec_addr_t(dec_addr_t), .dec_addr_d(dec_addr_d),
    .dec_imm(dec_imm), .dec_wr(dec_wr), .dec_wr_sel(dec_wr_sel),
    .addr_source(addr_source), .addr_temp(addr_temp), .addr_dest(addr_dest),
    .rf_s_data(rf_s_data), .rf_t_data(rf_t_data), .rf_d_data(rf_d_data),
    .wb_we(wb_we), .wb_control(wb_control), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_s(ex_s), .ex_t(ex_t), .ex_d(ex_d), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_wr_sel(ex_wr_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_s_data = rf[addr_source[3:0]];
  assign rf_t_data = rf[addr_temp[3:0]];
  assign rf_d_data = rf[addr_dest[3:0]];

  task automatic chk(input string name, input logic [141:0] act, input logic [141:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
    else passed++;
  endtask

  // ---------------- reference model ----------------
  logic         m_valid;
  logic [141:0] m_pkt;
  logic [15:0]  m_busy;

  function automatic logic [3:0] target(input logic [1:0] sel, input logic [4:0] a);
    if (sel == 2'b00) return a[3:0];
    if (sel == 2'b11) return 4'd11;
    return 4'd10;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx);
    logic [31:0] v;
    v = rf[idx[3:0]];
    if (wb_we) begin
      if (wb_control == 2'b00 && wb_addr[3:0] == idx[3:0]) v = wb_data;
      if (wb_control == 2'b01 && idx[3:0] == 4'd10) v[31:16] = wb_data[31:16];
      if (wb_control == 2'b10 && idx[3:0] == 4'd10) v[15:0] = wb_data[15:0];
      if (wb_control == 2'b11 && idx[3:0] == 4'd11) v = wb_data;
    end
    return v;
  endfunction

  function automatic logic blocked(input logic [4:0] idx);
    return m_busy[idx[3:0]] && !(wb_we && target(wb_control, wb_addr) == idx[3:0]);
  endfunction

  function automatic logic model_ready();
    return (!m_valid || ex_ready) && !(blocked(dec_addr_s) || blocked(dec_addr_t) || blocked(dec_addr_d));
  endfunction

  function automatic logic [15:0] next_busy(input logic iss);
    logic [15:0] b;
    b = m_busy;
    if (wb_we) b[target(wb_control, wb_addr)] = 1'b0;
    if (iss && dec_wr) b[target(dec_wr_sel, dec_addr_d)] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] wb_merged();
    logic [31:0] v;
    v = rf[target(wb_control, wb_addr)];
    if (wb_control == 2'b01) v[31:16] = wb_data[31:16];
    else if (wb_control == 2'b10) v[15:0] = wb_data[15:0];
    else v = wb_data;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_pkt   <= '0;
      m_busy  <= '0;
    end else begin
      if (dec_valid && model_ready()) begin
        m_valid <= 1'b1;
        m_pkt   <= {dec_op, operand(dec_addr_s), operand(dec_addr_t), operand(dec_addr_d),
                    {{16{dec_imm[15]}}, dec_imm}, dec_addr_d, dec_wr, dec_wr_sel};
      end else if (ex_ready) begin
        m_valid <= 1'b0;
      end
      m_busy <= next_busy(dec_valid && model_ready());
      if (wb_we) rf[target(wb_control, wb_addr)] <= wb_merged();
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_valid", ex_valid, 1'b0);
      chk("rst_bundle", {ex_op, ex_s, ex_t, ex_d, ex_imm, ex_rd, ex_wr, ex_wr_sel}, '0);
    end else begin
      chk("cyc_ready", dec_ready, model_ready());
      chk("cyc_valid", ex_valid, m_valid);
      if (m_valid)
        chk("cyc_bundle", {ex_op, ex_s, ex_t, ex_d, ex_imm, ex_rd, ex_wr, ex_wr_sel}, m_pkt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] imm, input logic wr,
                         input logic [1:0] sel);
    dec_valid = 1'b1; dec_op = op; dec_addr_s = s; dec_addr_t = t; dec_addr_d = d;
    dec_imm = imm; dec_wr = wr; dec_wr_sel = sel;
  endtask

  task automatic set_wb(input logic we, input logic [1:0] ctl, input logic [4:0] a,
                        input logic [31:0] dat);
    wb_we = we; wb_control = ctl; wb_addr = a; wb_data = dat;
  endtask

  initial begin
    reset = 1'b0;
    ex_ready = 1'b1;
    dec_valid = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0);
    dec_valid = 1'b0;
    set_wb(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) rf[i] = 32'h0101_0101 * i;
    rf[3]  = 32'h1111_1111;
    rf[5]  = 32'h5555_5555;
    rf[10] = 32'hAAAA_5555;
    rf[11] = 32'hBBBB_BBBB;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_valid", ex_valid, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_ready", dec_ready, 1'b1);

    // full-width bypass and negative immediate
    set_dec(6'd1, 5'd3, 5'd0, 5'd0, 16'h8001, 1'b0, 2'b00);
    set_wb(1'b1, 2'b00, 5'd3, 32'hDEAD_BEEF);
    step();
    chk("lit_valid_latency", ex_valid, 1'b1);
    chk("lit_full_bypass", ex_s, 32'hDEAD_BEEF);
    chk("lit_sext_neg", ex_imm, 32'hFFFF_8001);

    // half-word merges into r10
    set_dec(6'd2, 5'd10, 5'd0, 5'd0, 16'h7FFF, 1'b0, 2'b00);
    set_wb(1'b1, 2'b01, 5'd0, 32'h1234_FFFF);
    step();
    chk("lit_hi_merge", ex_s, 32'h1234_5555);
    chk("lit_sext_pos", ex_imm, 32'h0000_7FFF);
    rf[10] = 32'hAAAA_5555;
    set_dec(6'd3, 5'd0, 5'd10, 5'd0, 16'h0000, 1'b0, 2'b00);
    set_wb(1'b1, 2'b10, 5'd0, 32'hFFFF_9876);
    step();
    chk("lit_lo_merge", ex_t, 32'hAAAA_9876);

    // scoreboard stall on r5
    set_wb(1'b0, 2'b00, 5'd0, 32'h0);
    set_dec(6'd4, 5'd0, 5'd0, 5'd5, 16'h0, 1'b1, 2'b00);
    step();
    chk("lit_writer_rd", ex_rd, 5'd5);
    set_dec(6'd5, 5'd5, 5'd0, 5'd0, 16'h0, 1'b0, 2'b00);
    @(negedge clk) chk("lit_raw_stall0", dec_ready, 1'b0);
    step();
    @(negedge clk) chk("lit_raw_stall1", dec_ready, 1'b0);
    step();
    set_wb(1'b1, 2'b00, 5'd5, 32'hCAFE_F00D);
    @(negedge clk) chk("lit_raw_release", dec_ready, 1'b1);
    step();
    chk("lit_raw_bypass", ex_s, 32'hCAFE_F00D);
    chk("lit_raw_op", ex_op, 6'd5);

    // set wins over clear on r11
    set_wb(1'b1, 2'b11, 5'd0, 32'h0BAD_CAFE);
    set_dec(6'd6, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 2'b11);
    step();
    set_wb(1'b0, 2'b00, 5'd0, 32'h0);
    set_dec(6'd7, 5'd11, 5'd0, 5'd0, 16'h0, 1'b0, 2'b00);
    @(negedge clk) chk("lit_collision_busy", dec_ready, 1'b0);
    step();
    set_wb(1'b1, 2'b11, 5'd0, 32'h1234_5678);
    @(negedge clk) chk("lit_collision_release", dec_ready, 1'b1);
    step();
    chk("lit_aux_bypass", ex_s, 32'h1234_5678);

    // backpressure then back-to-back issue
    set_wb(1'b0, 2'b00, 5'd0, 32'h0);
    set_dec(6'd8, 5'd1, 5'd2, 5'd4, 16'h0042, 1'b0, 2'b00);
    step();
    ex_ready = 1'b0;
    set_dec(6'd9, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_bp_ready", dec_ready, 1'b0);
      chk("lit_bp_hold", {ex_valid, ex_op, ex_s, ex_imm}, {1'b1, 6'd8, 32'h0101_0101, 32'h0000_0042});
      step();
    end
    ex_ready = 1'b1;
    @(negedge clk) chk("lit_bp_release", dec_ready, 1'b1);
    step();
    chk("lit_b2b_0", ex_op, 6'd9);
    set_dec(6'd10, 5'd2, 5'd2, 5'd2, 16'h0, 1'b0, 2'b00);
    step();
    chk("lit_b2b_1", ex_op, 6'd10);
    set_dec(6'd11, 5'd3, 5'd3, 5'd3, 16'h0, 1'b0, 2'b00);
    step();
    chk("lit_b2b_2", {ex_valid, ex_op}, {1'b1, 6'd11});
    dec_valid = 1'b0;
    step();
    chk("lit_drain", ex_valid, 1'b0);

    // reset in the middle of a stall
    set_dec(6'd12, 5'd0, 5'd0, 5'd6, 16'h0, 1'b1, 2'b00);
    step();
    ex_ready = 1'b0;
    set_dec(6'd13, 5'd6, 5'd0, 5'd0, 16'h0, 1'b0, 2'b00);
    step();
    #2 reset = 1'b0;
    #1 chk("lit_async_rst", {ex_valid, ex_op}, '0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk) chk("lit_rst_busy_clear", dec_ready, 1'b1);
    step();
    chk("lit_rst_issue", {ex_valid, ex_op}, {1'b1, 6'd13});
    dec_valid = 1'b0;
    ex_ready = 1'b1;
    repeat (2) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
